cirno9_axi_arb: RTL and testbench

- Two-port arbiter and sequencer for the core's single AXI4 master port.
- Requester 0 is instruction fetch; requester 1 is load/store for non-SRAM addresses.
- Captures one request at a time and issues one single-beat AXI4 read or write (awlen/arlen=0).
- Returns a one-cycle response pulse to the owning requester. Sits between the core pipeline and the top-level m_axi_* bus.

---
 rtl/cirno9_axi_pkg.sv | 30 +++
 rtl/cirno9_arb2.sv | 43 ++++
 rtl/cirno9_axi_arb.sv | 190 +++++++++++++++++++
 tb/tb_cirno9_axi_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cirno9_axi_pkg.sv
// rtl/cirno9_axi_pkg.sv - state encodings, AXI constants and requester ids for cirno9_axi_arb
package cirno9_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_AW,
    ST_WR_B
  } state_t;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      RESP_OKAY, RESP_EXOKAY: resp_is_err = 1'b0;
      default:                resp_is_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cirno9_arb2.sv
// rtl/cirno9_arb2.sv - two-requester grant; CIRNO9_AXI_ARB_RR_EN selects round-robin,
// otherwise fixed priority with load/store over instruction fetch
module cirno9_arb2
  import cirno9_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_val,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef CIRNO9_AXI_ARB_RR_EN
  logic last_id;

  // On contention, favour whoever was not served last
  always_comb begin
    grant = req_val;
    if (req_val == 2'b11) begin
      grant = (last_id == REQ_LSU) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= REQ_IFU;
    end else if (accept) begin
      last_id <= grant[REQ_LSU];
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, accept};

  always_comb begin
    grant = req_val;
    if (req_val[REQ_LSU]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/cirno9_axi_arb.sv
// rtl/cirno9_axi_arb.sv - fetch/load-store arbiter driving one single-beat AXI4 master;
// arbitration mode set by CIRNO9_AXI_ARB_RR_EN (see cirno9_arb2)
module cirno9_axi_arb
  import cirno9_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_val,
  output logic [1:0]            req_rdy,
  input  logic [1:0]            req_wr,
  input  logic [2*ADDR_W-1:0]   req_adr,
  input  logic [2*DATA_W-1:0]   req_wdat,
  input  logic [2*DATA_W/8-1:0] req_wstrb,
  output logic [1:0]            rsp_val,
  output logic [DATA_W-1:0]     rsp_rdat,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_t                state;
  logic [1:0]            grant;
  logic                  accept;
  logic                  win_id;
  logic                  owner;
  logic [ADDR_W-1:0]     cap_adr;
  logic [DATA_W-1:0]     cap_wdat;
  logic [DATA_W/8-1:0]   cap_wstrb;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_fire;
  logic                  w_fire;
  logic [1:0]            owner_hot;
  logic                  unused_rlast;

  cirno9_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_val (req_val),
    .accept  (accept),
    .grant   (grant)
  );

  assign req_rdy   = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_val & req_rdy);
  assign win_id    = grant[REQ_LSU] ? REQ_LSU : REQ_IFU;
  assign aw_fire   = m_axi_awvalid & m_axi_awready;
  assign w_fire    = m_axi_wvalid & m_axi_wready;
  assign owner_hot = (owner == REQ_LSU) ? 2'b10 : 2'b01;

  assign m_axi_awaddr  = cap_adr;
  assign m_axi_araddr  = cap_adr;
  assign m_axi_wdata   = cap_wdat;
  assign m_axi_wstrb   = cap_wstrb;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_arqos   = 4'd0;

  // Single-beat transfers only, so the last flag carries no information
  assign unused_rlast = m_axi_rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= REQ_IFU;
      cap_adr       <= '0;
      cap_wdat      <= '0;
      cap_wstrb     <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_val       <= 2'b00;
      rsp_rdat      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      rsp_val <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner     <= win_id;
            cap_adr   <= win_id ? req_adr[2*ADDR_W-1:ADDR_W] : req_adr[ADDR_W-1:0];
            cap_wdat  <= win_id ? req_wdat[2*DATA_W-1:DATA_W] : req_wdat[DATA_W-1:0];
            cap_wstrb <= win_id ? req_wstrb[2*DATA_W/8-1:DATA_W/8] : req_wstrb[DATA_W/8-1:0];
            if (req_wr[win_id]) begin
              state         <= ST_WR_AW;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
            end else begin
              state         <= ST_RD_A;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        ST_RD_A: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdat     <= m_axi_rdata;
            rsp_err      <= resp_is_err(m_axi_rresp);
            rsp_val      <= owner_hot;
            state        <= ST_IDLE;
          end
        end
        ST_WR_AW: begin
          if (aw_fire) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_fire) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          // Address and data handshakes may land in either order or together
          if ((aw_done | aw_fire) & (w_done | w_fire)) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_err      <= resp_is_err(m_axi_bresp);
            rsp_val      <= owner_hot;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cirno9_axi_arb.sv
// tb/tb_cirno9_axi_arb.sv - randomized self-checking bench for cirno9_axi_arb (honours CIRNO9_AXI_ARB_RR_EN)
module tb_cirno9_axi_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_val, req_rdy, req_wr, rsp_val;
  logic [63:0] req_adr, req_wdat;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdat;
  logic        rsp_err;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready, m_axi_awlock, m_axi_arlock;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_wstrb;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        model_last;
  logic [31:0] model_rdat;

  always #5 clk = ~clk;

  cirno9_axi_arb dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_adr(req_adr), .req_wdat(req_wdat), .req_wstrb(req_wstrb),
    .rsp_val(rsp_val), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awqos(m_axi_awqos), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Who should win given the request vector and who was served last
  function automatic logic [1:0] model_grant(input logic [1:0] v);
    if (v != 2'b11) return v;
`ifdef CIRNO9_AXI_ARB_RR_EN
    return model_last ? 2'b01 : 2'b10;
`else
    return 2'b10;
`endif
  endfunction

  task automatic slave_idle();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
  endtask

  task automatic do_reset();
    rst = 1; req_val = 0; req_wr = 0; req_adr = 0; req_wdat = 0; req_wstrb = 0;
    slave_idle();
    repeat (2) @(negedge clk);
    rst = 0;
    model_last = 1'b0;
    model_rdat = 32'h0;
  endtask

  // Caller is at a negedge. Runs one transaction against a slave with the given
  // address/data/response delays and checks channel contents and the response.
  task automatic run_txn(input logic [1:0] val, input logic [1:0] wr, input logic [63:0] adr,
                         input logic [63:0] wdat, input logic [7:0] strb,
                         input int a_dly, input int w_dly, input int d_dly,
                         input logic [31:0] rd_v, input logic [1:0] resp_v, input bit hold,
                         output int lat, output int a_cyc, output int w_cyc,
                         output logic [1:0] got_rsp, output logic is_wr);
    logic [1:0]  exp_g, exp_rsp;
    logic [31:0] exp_adr, exp_wdat, exp_rdat;
    logic [3:0]  exp_strb;
    int          id, a_cnt, w_cnt, d_cnt;
    bit          a_hs, w_hs, seen, a_now, w_now;
    exp_g    = model_grant(val);
    id       = exp_g[1] ? 1 : 0;
    is_wr    = wr[id];
    exp_adr  = adr[id*32 +: 32];
    exp_wdat = wdat[id*32 +: 32];
    exp_strb = strb[id*4 +: 4];
    exp_rsp  = exp_g;
    exp_rdat = is_wr ? model_rdat : rd_v;
    req_val = val; req_wr = wr; req_adr = adr; req_wdat = wdat; req_wstrb = strb;
    #1;
    n_checks++;
    if (req_rdy !== exp_g) begin
      n_errors++; $display("FAIL grant: req_rdy=%b expected %b", req_rdy, exp_g);
    end
    @(posedge clk); #1;
    model_last = id[0];
    if (!hold) req_val = 2'b00;
    lat = 0; a_cyc = 0; w_cyc = 0; got_rsp = 0;
    a_cnt = 0; w_cnt = 0; d_cnt = 0; a_hs = 0; w_hs = 0; seen = 0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      a_now = 0; w_now = 0;
      if (rsp_val !== 2'b00) begin
        seen = 1; lat = c; got_rsp = rsp_val;
        n_checks++;
        if (rsp_val !== exp_rsp || rsp_rdat !== exp_rdat || rsp_err !== resp_v[1]) begin
          n_errors++;
          $display("FAIL response: val=%b rdat=%h err=%b expected val=%b rdat=%h err=%b",
                   rsp_val, rsp_rdat, rsp_err, exp_rsp, exp_rdat, resp_v[1]);
        end
        slave_idle();
      end else begin
        n_checks++;
        if (req_rdy !== 2'b00) begin
          n_errors++; $display("FAIL busy_rdy: req_rdy=%b expected 00 at cycle %0d", req_rdy, c);
        end
        if (!is_wr) begin
          if (!a_hs) begin
            n_checks++; a_cyc++;
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== exp_adr) begin
              n_errors++;
              $display("FAIL ar_chan: arvalid=%b araddr=%h expected 1 %h at cycle %0d",
                       m_axi_arvalid, m_axi_araddr, exp_adr, c);
            end
            m_axi_arready = (a_cnt >= a_dly); a_cnt++; a_now = m_axi_arready;
          end else begin
            m_axi_arready = 0;
            m_axi_rvalid = (d_cnt >= d_dly); d_cnt++;
            m_axi_rdata = rd_v; m_axi_rresp = resp_v; m_axi_rlast = 1;
            n_checks++;
            if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1) begin
              n_errors++;
              $display("FAIL rd_phase: arvalid=%b rready=%b expected 0 1", m_axi_arvalid, m_axi_rready);
            end
          end
          a_hs = a_hs | a_now;
        end else if (!(a_hs && w_hs)) begin
          n_checks++;
          if (!a_hs) begin
            a_cyc++;
            if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== exp_adr) begin
              n_errors++;
              $display("FAIL aw_chan: awvalid=%b awaddr=%h expected 1 %h at cycle %0d",
                       m_axi_awvalid, m_axi_awaddr, exp_adr, c);
            end
            m_axi_awready = (a_cnt >= a_dly); a_cnt++; a_now = m_axi_awready;
          end else begin
            m_axi_awready = 0;
            if (m_axi_awvalid !== 1'b0) begin
              n_errors++; $display("FAIL aw_drop: awvalid=%b expected 0 at cycle %0d", m_axi_awvalid, c);
            end
          end
          n_checks++;
          if (!w_hs) begin
            w_cyc++;
            if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== exp_wdat || m_axi_wstrb !== exp_strb ||
                m_axi_wlast !== 1'b1) begin
              n_errors++;
              $display("FAIL w_chan: wvalid=%b wdata=%h wstrb=%h wlast=%b expected 1 %h %h 1",
                       m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, exp_wdat, exp_strb);
            end
            m_axi_wready = (w_cnt >= w_dly); w_cnt++; w_now = m_axi_wready;
          end else begin
            m_axi_wready = 0;
            if (m_axi_wvalid !== 1'b0) begin
              n_errors++; $display("FAIL w_drop: wvalid=%b expected 0 at cycle %0d", m_axi_wvalid, c);
            end
          end
          a_hs = a_hs | a_now; w_hs = w_hs | w_now;
        end else begin
          m_axi_awready = 0; m_axi_wready = 0;
          m_axi_bvalid = (d_cnt >= d_dly); d_cnt++; m_axi_bresp = resp_v;
          n_checks++;
          if (m_axi_bready !== 1'b1) begin
            n_errors++; $display("FAIL bready: bready=%b expected 1", m_axi_bready);
          end
        end
      end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: no rsp_val within 200 cycles");
      slave_idle();
    end
    if (!is_wr) model_rdat = rd_v;
    if (!hold) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_val !== 2'b00) begin
        n_errors++; $display("FAIL rsp_pulse: rsp_val=%b expected 00 one cycle later", rsp_val);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0 ||
        req_rdy !== 2'b00 || rsp_val !== 2'b00 || rsp_rdat !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: valids=%b req_rdy=%b rsp_val=%b rdat=%h err=%b expected all 0",
               {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready},
               req_rdy, rsp_val, rsp_rdat, rsp_err);
    end
    n_checks++;
    if ({m_axi_awlen, m_axi_arlen, m_axi_awsize, m_axi_arsize, m_axi_awburst, m_axi_arburst,
         m_axi_awlock, m_axi_arlock, m_axi_awcache, m_axi_arcache, m_axi_awprot, m_axi_arprot,
         m_axi_awqos, m_axi_arqos} !==
        {8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b0, 1'b0, 4'b0011, 4'b0011,
         3'b000, 3'b000, 4'd0, 4'd0}) begin
      n_errors++;
      $display("FAIL tie_offs: len=%h/%h size=%b/%b burst=%b/%b cache=%h/%h expected 0/0 010 01 3",
               m_axi_awlen, m_axi_arlen, m_axi_awsize, m_axi_arsize, m_axi_awburst, m_axi_arburst,
               m_axi_awcache, m_axi_arcache);
    end
    req_val = 2'b01; #1;
    n_checks++;
    if (req_rdy !== 2'b01) begin
      n_errors++; $display("FAIL idle_rdy: req_rdy=%b expected 01", req_rdy);
    end
    req_val = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat, a_cyc, w_cyc; logic [1:0] got; logic is_wr;
    run_txn(2'b01, 2'b00, {32'h0, 32'h8000_0010}, 64'h0, 8'h0, 0, 0, 0,
            32'hDEAD_BEEF, 2'b00, 0, lat, a_cyc, w_cyc, got, is_wr);
    n_checks++;
    if (lat != 3 || a_cyc != 1) begin
      n_errors++; $display("FAIL read_latency: lat=%0d ar_cycles=%0d expected 3 1", lat, a_cyc);
    end
  endtask

  task automatic test_write_skew();
    int lat, a_cyc, w_cyc; logic [1:0] got; logic is_wr;
    run_txn(2'b10, 2'b10, {32'h9000_0040, 32'h0}, {32'h1234_5678, 32'h0}, 8'h60, 3, 0, 0,
            32'h0, 2'b10, 0, lat, a_cyc, w_cyc, got, is_wr);
    n_checks++;
    if (w_cyc != 1 || a_cyc != 4 || lat != 6) begin
      n_errors++;
      $display("FAIL write_skew: w_cycles=%0d aw_cycles=%0d lat=%0d expected 1 4 6", w_cyc, a_cyc, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, a_cyc, w_cyc; logic [1:0] got; logic is_wr;
    logic [1:0] exp_seq [4];
`ifdef CIRNO9_AXI_ARB_RR_EN
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
              0, 0, 0, $urandom, 2'b00, 1, lat, a_cyc, w_cyc, got, is_wr);
      n_checks++;
      if (got !== exp_seq[i] || lat != 3) begin
        n_errors++;
        $display("FAIL contention[%0d]: owner=%b lat=%0d expected %b 3", i, got, lat, exp_seq[i]);
      end
    end
    req_val = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat, a_cyc, w_cyc; logic [1:0] got; logic is_wr;
    run_txn(2'b11, 2'b00, {32'hC000_0008, 32'hC000_0004}, 64'h0, 8'h0, 5, 0, 0,
            32'h5A5A_0F0F, 2'b01, 1, lat, a_cyc, w_cyc, got, is_wr);
    req_val = 2'b00;
    n_checks++;
    if (a_cyc != 6 || lat != 8) begin
      n_errors++; $display("FAIL backpressure: ar_cycles=%0d lat=%0d expected 6 8", a_cyc, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int lat, a_cyc, w_cyc; logic [1:0] got; logic is_wr;
    req_val = 2'b01; req_wr = 2'b00; req_adr = {32'h0, 32'hA000_0000};
    @(posedge clk); #1;
    req_val = 2'b00;
    @(negedge clk);
    m_axi_arready = 1;
    @(negedge clk);
    m_axi_arready = 0;
    n_checks++;
    if (m_axi_rready !== 1'b1) begin
      n_errors++; $display("FAIL midflight_rd_d: rready=%b expected 1", m_axi_rready);
    end
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0 ||
        rsp_val !== 2'b00 || req_rdy !== 2'b00) begin
      n_errors++;
      $display("FAIL midflight_reset: valids=%b rsp_val=%b req_rdy=%b expected 0",
               {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready},
               rsp_val, req_rdy);
    end
    rst = 0; model_last = 1'b0; model_rdat = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_val !== 2'b00) begin
        n_errors++; $display("FAIL midflight_no_rsp: rsp_val=%b expected 00", rsp_val);
      end
    end
    run_txn(2'b01, 2'b00, {32'h0, 32'hA000_0100}, 64'h0, 8'h0, 0, 0, 0,
            32'hCAFE_F00D, 2'b00, 0, lat, a_cyc, w_cyc, got, is_wr);
    n_checks++;
    if (lat != 3) begin
      n_errors++; $display("FAIL midflight_recover: lat=%0d expected 3", lat);
    end
  endtask

  task automatic test_random();
    int lat, a_cyc, w_cyc, a, w, d, exp_lat; logic [1:0] got; logic is_wr;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 3); w = $urandom_range(0, 3); d = $urandom_range(0, 3);
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              8'($urandom), a, w, d, $urandom, 2'($urandom), 0, lat, a_cyc, w_cyc, got, is_wr);
      exp_lat = is_wr ? 3 + ((a > w) ? a : w) + d : 3 + a + d;
      n_checks++;
      if (lat != exp_lat) begin
        n_errors++;
        $display("FAIL random_latency[%0d]: lat=%0d expected %0d (wr=%b a=%0d w=%0d d=%0d)",
                 i, lat, exp_lat, is_wr, a, w, d);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write_skew();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
